// File: rtl/alu_op_issue.sv
// ALU operand/control issue and result collect stage.
// Decodes ALUOp/funct into the 4-bit ALU control code, registers the op into
// an EX stage that drives the combinational ALU, then captures the ALU result
// into a WB stage presented downstream. Two stages, full valid/ready backpressure.
module alu_op_issue #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        aluop_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              illegal_o
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  logic       ex_valid;
  logic       ex_illegal;
  logic       wb_valid;
  logic       wb_adv;
  logic       xfer_in;
  logic [3:0] dec_ctrl;
  logic       dec_illegal;

  // Handshake: WB can move when empty or being drained; EX can take a new op
  // when empty or when its current op moves into WB.
  assign wb_adv      = ~wb_valid | out_ready_i;
  assign in_ready_o  = ~ex_valid | wb_adv;
  assign xfer_in     = in_valid_i & in_ready_o;
  assign out_valid_o = wb_valid;

  // Decode ALUOp/funct into the ALU control code; anything undefined is illegal.
  always_comb begin
    dec_ctrl    = CTRL_BAD;
    dec_illegal = 1'b1;
    case (aluop_i)
      3'b000: begin dec_ctrl = CTRL_ADD; dec_illegal = 1'b0; end
      3'b001: begin dec_ctrl = CTRL_SUB; dec_illegal = 1'b0; end
      3'b011: begin dec_ctrl = CTRL_OR;  dec_illegal = 1'b0; end
      3'b100: begin dec_ctrl = CTRL_SLT; dec_illegal = 1'b0; end
      3'b010: begin
        case (funct_i)
          6'b100000: begin dec_ctrl = CTRL_ADD; dec_illegal = 1'b0; end
          6'b100010: begin dec_ctrl = CTRL_SUB; dec_illegal = 1'b0; end
          6'b100100: begin dec_ctrl = CTRL_AND; dec_illegal = 1'b0; end
          6'b100101: begin dec_ctrl = CTRL_OR;  dec_illegal = 1'b0; end
          6'b101010: begin dec_ctrl = CTRL_SLT; dec_illegal = 1'b0; end
          default: begin
            dec_ctrl    = CTRL_BAD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl    = CTRL_BAD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // EX stage: capture a new op on transfer in; operands hold when the stage empties.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
      alu_ctrl_o <= 4'b0000;
      alu_src1_o <= '0;
      alu_src2_o <= '0;
    end else if (xfer_in) begin
      ex_valid   <= 1'b1;
      ex_illegal <= dec_illegal;
      alu_ctrl_o <= dec_ctrl;
      alu_src1_o <= src1_i;
      alu_src2_o <= src2_i;
    end else if (wb_adv) begin
      ex_valid <= 1'b0;
    end
  end

  // WB stage: capture the ALU output when EX advances; illegal ops report 0 / zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_valid  <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else if (wb_adv) begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        illegal_o <= ex_illegal;
        if (ex_illegal) begin
          result_o <= '0;
          zero_o   <= 1'b1;
        end else begin
          result_o <= alu_result_i;
          zero_o   <= alu_zero_i;
        end
      end
    end
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Issue/collect stage on the initiator side of the ALU operand/control interface: it produces `src1`/`src2`/4-bit `ctrl` for the ALU and consumes `result`/`zero`.
- Accepts decoded instruction fields (ALUOp, funct, operands) over a valid/ready handshake and decodes them into the ALU's 4-bit control code.
- Registers them into an EX stage that drives the combinational ALU, then captures the ALU result into a WB stage presented downstream with valid/ready.
- Two-stage pipeline with full backpressure; it sits between the CPU's ID stage and the writeback/branch logic.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  asynchronous reset, active-low
- in_valid_i  input  1  upstream op valid
- in_ready_o  output  1  stage can accept an op this cycle
- aluop_i  input  3  ALUOp from main control
- funct_i  input  6  R-type funct field
- src1_i  input  DATA_W  operand 1
- src2_i  input  DATA_W  operand 2 (register or sign-extended immediate, selected upstream)
- alu_ctrl_o  output  4  control code to ALU
- alu_src1_o  output  DATA_W  operand 1 to ALU
- alu_src2_o  output  DATA_W  operand 2 to ALU
- alu_result_i  input  DATA_W  ALU result (combinational from alu_* outputs)
- alu_zero_i  input  1  ALU zero flag
- out_valid_o  output  1  WB result valid
- out_ready_i  input  1  downstream accepts result
- result_o  output  DATA_W  captured result
- zero_o  output  1  captured zero flag
- illegal_o  output  1  captured op was an undefined ALUOp/funct combination

Behaviour:
- Reset (rst_i=0, asynchronous, any cycle including mid-operation):
  - ex_valid=0, wb_valid=0; all pending ops discarded.
  - alu_ctrl_o=4'b0000, alu_src1_o=0, alu_src2_o=0.
  - out_valid_o=0, result_o=0, zero_o=0, illegal_o=0.
- Decode, combinational on the input side:
  - ALUOp 000 -> 0010 (add, lw/sw/addi)
  - ALUOp 001 -> 0110 (sub, beq)
  - ALUOp 011 -> 0001 (or, ori)
  - ALUOp 100 -> 0111 (slt, slti)
  - ALUOp 010 (R-type), by funct: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111.
  - Any other ALUOp, or any other funct under ALUOp 010: illegal. Code 4'b1111 is sent to the ALU; the illegal bit travels with the op.
- Handshake:
  - wb_adv = ~wb_valid | out_ready_i.
  - in_ready_o = ~ex_valid | wb_adv (combinational, no dependence on in_valid_i).
  - Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
- EX stage:
  - On transfer in, capture ctrl/src1/src2/illegal and set ex_valid=1.
  - Else if wb_adv, clear ex_valid.
  - alu_* outputs hold their last captured values while ex_valid=0; they are not cleared.
- WB stage:
  - When wb_adv & ex_valid: result_o<=alu_result_i, zero_o<=alu_zero_i, illegal_o<=ex_illegal, wb_valid<=1.
  - When wb_adv & ~ex_valid: wb_valid<=0, data held.
  - If the EX op is illegal, result_o<=0 and zero_o<=1, regardless of the ALU output.
- Latency: an op accepted at edge N is on out_valid_o after edge N+1, with no stalls.
- Throughput: 1 op/cycle with out_ready_i held high.
- Backpressure:
  - With out_ready_i=0 and wb_valid=1, WB holds and EX holds.
  - in_ready_o=0 while ex_valid=1.
  - At most 2 ops are in flight.
- Simultaneous events:
  - Transfer out and EX advance in the same cycle: WB takes the new EX op; no bubble.
  - Transfer in and EX advance in the same cycle: EX takes the new op.
- Outputs stable under stall: result_o, zero_o and illegal_o must not change while out_valid_o=1 and out_ready_i=0.
- Operand values: passed through unmodified; signed handling is the ALU's responsibility.

Test Plan:
- Reset then R-type add: aluop=010, funct=100000, src1=5, src2=7, out_ready=1.
  - alu_ctrl_o=0010 one cycle after accept.
  - out_valid_o=1 one cycle later with result_o=12, zero_o=0, illegal_o=0.
- Back-to-back stream with out_ready=1: sub(9,9), slt(-3,2), or(0xF0,0x0F), beq(4,4).
  - Results 0/z=1, 1/z=0, 0xFF/z=0, 0/z=1 on consecutive cycles.
  - in_ready_o stays 1 throughout.
- Backpressure: hold out_ready=0 with 3 ops offered.
  - 2 accepted; in_ready_o=0 thereafter.
  - result_o stable on the first op.
  - Release: results drain in order, then the third op is accepted.
- Illegal op: aluop=010, funct=000000, src1=1, src2=1 -> alu_ctrl_o=1111; out gives illegal_o=1, result_o=0, zero_o=1.
- Immediate ops: aluop=011 with src2=0x0000FFFF, src1=0x00010000 -> result 0x0001FFFF; aluop=100 with src1=-1, src2=0 -> result 1.
- Asynchronous reset asserted mid-stream, between clock edges, with 2 ops in flight:
  - out_valid_o=0 and alu_ctrl_o=0000 immediately, without waiting for a clock edge.
  - After release, no stale op appears on the output.
